// File: rtl/led_pattern_gen.sv
// LED pattern sequencer: rotate-left, rotate-right, bounce, binary count and
// blink patterns. It advances on an internal prescaler enable or on a manual step pulse.
module led_pattern_gen #(
    parameter int NUM_LEDS = 4,
    parameter int DIV      = 12500000
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                en,
    input  logic [2:0]          mode,
    input  logic [1:0]          speed,
    input  logic                step,
    output logic                tick,
    output logic [NUM_LEDS-1:0] led
);

    localparam int CW = $clog2(DIV);

    typedef enum logic [2:0] {
        ROT_L  = 3'd0,
        ROT_R  = 3'd1,
        BOUNCE = 3'd2,
        COUNT  = 3'd3,
        BLINK  = 3'd4
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [CW-1:0]       count;
    logic [2:0]          mode_q;
    logic                started;
    dir_t                dir;

    logic [31:0]         lim_m1;
    logic                natural;
    logic                adv;
    logic                mode_chg;
    logic [NUM_LEDS-1:0] seed;
    logic [NUM_LEDS-1:0] next_led;
    dir_t                next_dir;

    // Prescaler compare and advance qualification.
    always_comb begin
        lim_m1   = (32'(DIV) >> speed) - 32'd1;
        natural  = en && (32'(count) >= lim_m1);
        adv      = natural || step;
        mode_chg = (mode != mode_q);
    end

    // Seed for the first advance and the pattern's next value after it.
    always_comb begin
        seed     = NUM_LEDS'(1);
        next_led = {led[NUM_LEDS-2:0], led[NUM_LEDS-1]};
        next_dir = dir;
        case (mode_q)
            ROT_R: begin
                seed     = {1'b1, {(NUM_LEDS-1){1'b0}}};
                next_led = {led[0], led[NUM_LEDS-1:1]};
            end
            BOUNCE: begin
                if (dir == DIR_UP) begin
                    next_led = led << 1;
                    if (next_led[NUM_LEDS-1]) next_dir = DIR_DOWN;
                end else begin
                    next_led = led >> 1;
                    if (next_led[0]) next_dir = DIR_UP;
                end
            end
            COUNT: next_led = led + NUM_LEDS'(1);
            BLINK: begin
                seed     = '1;
                next_led = ~led;
            end
            default: ;
        endcase
    end

    // Sequencer state: a mode change clears the pattern and drops any advance in the same cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count   <= '0;
            mode_q  <= '0;
            started <= 1'b0;
            dir     <= DIR_UP;
            led     <= '0;
            tick    <= 1'b0;
        end else begin
            mode_q <= mode;
            if (mode_chg) begin
                count   <= '0;
                started <= 1'b0;
                dir     <= DIR_UP;
                led     <= '0;
                tick    <= 1'b0;
            end else begin
                if (en) count <= natural ? '0 : count + CW'(1);
                tick <= adv;
                if (adv) begin
                    if (!started) begin
                        led     <= seed;
                        started <= 1'b1;
                    end else begin
                        led <= next_led;
                        dir <= next_dir;
                    end
                end
            end
        end
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised LED sequencer for the board LED bank. It generates rotate, bounce, binary-count and blink patterns on NUM_LEDS outputs.
- Step rate comes from an internal prescaler that produces a single-cycle clock-enable. There is no derived clock; everything runs in the clk domain.
- Sits between board-level mode/speed controls (switches or a register) and the LED pins. It replaces fixed-pattern LED drivers.

Parameters:
- NUM_LEDS, 4, number of LED outputs; legal range ≥2.
- DIV, 12500000, base step period in clk cycles at speed=0; legal range ≥4.

Ports:
- clk  input  1  system clock
- nrst  input  1  reset
- en  input  1  1 = free-running stepping; 0 = prescaler frozen
- mode  input  3  pattern select: 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 COUNT, 4 BLINK; 5-7 behave as ROT_L
- speed  input  2  step period = DIV >> speed cycles
- step  input  1  single-cycle manual advance pulse
- tick  output  1  one-cycle pulse on every pattern advance
- led  output  NUM_LEDS  LED drive, active-high

Interface (already decided): reset nrst, asynchronous, active-low; clock clk.

Behaviour:
- Reset values: led=0, tick=0, prescaler count=0, started=0, dir=up, mode_q=0.
- Prescaler:
  - limit = DIV>>speed; counter width clog2(DIV).
  - With en=1, count increments each cycle. When count ≥ limit-1: count←0 and a natural tick fires.
  - The ≥ compare covers a speed change that leaves count above the new limit: that wraps immediately with a tick.
  - With en=0, count holds and no natural tick fires.
- Advance: adv = natural tick OR step. A natural tick and step in the same cycle produce one advance only. step works regardless of en and does not touch count.
- tick output: registered, high the cycle after adv, exactly one cycle per advance.
- Mode change:
  - mode_q registers mode every cycle. If mode ≠ mode_q: led←0, started←0, dir←up, count←0.
  - Mode change has priority over adv in the same cycle; that adv is dropped and tick stays 0.
- First advance after reset or mode change (started=0): led←seed, started←1.
  - Seeds: ROT_L, BOUNCE, COUNT → 0…01. ROT_R → 10…0. BLINK → all ones.
- Subsequent advances (started=1):
  - ROT_L: rotate toward MSB, with the MSB wrapping to bit0. Example (N=4): 0001→0010→0100→1000→0001.
  - ROT_R: rotate toward LSB, with bit0 wrapping to the MSB.
  - BOUNCE: one-hot moves toward the MSB while dir=up. On reaching the MSB, dir flips down on the same advance; on reaching bit0, dir flips up. Each end LED is lit for one step. Sequence for N=4: 0001,0010,0100,1000,0100,0010,0001,0010…
  - COUNT: led←led+1 modulo 2^NUM_LEDS; all ones wraps to 0.
  - BLINK: led←~led (all on / all off).
- led changes only on adv, mode change or reset. All outputs are registered.
- Reset asserted mid-pattern: all state returns to reset values immediately (asynchronous). After deassertion the sequence restarts from the seed on the first advance.

Test Plan:
- Legacy sequence: DIV=4, N=4, mode=0, speed=0, en=1, release reset → led=0000 until first tick at cycle 4, then 0001,0010,0100,1000,0001 every 4 cycles; tick is a 1-cycle pulse each time.
- Bounce: N=4, mode=2, DIV=4 → 0001,0010,0100,1000,0100,0010,0001,0010 across 8 ticks; no repeated end value.
- Speed/COUNT: DIV=16, speed=2, mode=3 → one advance per 4 cycles; after 16 advances led returns 1111→0000 then 0001. Switching speed 0→3 when count=10 → tick on the next cycle.
- Manual step: en=0, pulse step 3 times → led 0001,0010,0100; count frozen. Step coincident with a natural tick (en=1) → single advance, single tick.
- Mode change mid-pattern: in ROT_L at led=0100, set mode=1 → next cycle led=0000 and count=0. Next tick → 1000, then 0100. An adv in the change cycle is ignored.
- Reset mid-operation: assert nrst low in BLINK with led=1111 → led=0000 asynchronously, tick=0. After release, first tick → 1111.
